// File: rtl/multi_grant_arbiter.sv
// rtl/multi_grant_arbiter.sv - registered K-of-M grant selector (top-down, bottom-up, round-robin).
// Optional perf counters grant_cnt/stall_cnt are built when ARB_PERF_CNT_EN is defined.
module multi_grant_arbiter #(
  parameter int M = 16,
  parameter int K = 2,
  parameter int N = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [M-1:0]   req,
  input  logic [1:0]     mode,
  input  logic           flush,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [K-1:0]   grant_valid,
  output logic [K*N-1:0] grant_idx,
  output logic [M-1:0]   grant_onehot,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]    grant_cnt,
  output logic [31:0]    stall_cnt,
`endif
  output logic [N-1:0]   rr_ptr
);

  logic           advance;
  logic [K-1:0]   sel_valid;
  logic [K*N-1:0] sel_idx;
  logic [M-1:0]   sel_onehot;
  logic           any_sel;
  logic [N-1:0]   next_ptr;

  assign advance = !out_valid || out_ready;

  // Walk the M positions in priority order; each position is visited exactly once.
  always_comb begin
    int cnt;
    int p;
    int last;
    logic [N-1:0] pos;
    sel_valid  = '0;
    sel_idx    = '0;
    sel_onehot = '0;
    cnt        = 0;
    last       = 0;
    p          = 0;
    pos        = '0;
    for (int o = 0; o < M; o++) begin
      if (mode == 2'b00) begin
        p = M - 1 - o;
      end else if (mode == 2'b01) begin
        p = o;
      end else begin
        p = int'(rr_ptr) + o;
        if (p >= M) p = p - M;
      end
      pos = p[N-1:0];
      if (req[pos] && cnt < K) begin
        for (int j = 0; j < K; j++) begin
          if (j == cnt) begin
            sel_valid[j]        = 1'b1;
            sel_idx[j*N +: N]   = pos;
          end
        end
        sel_onehot[pos] = 1'b1;
        last            = p;
        cnt             = cnt + 1;
      end
    end
    any_sel  = (cnt > 0);
    // Explicit wrap keeps the pointer below M for non-power-of-2 M.
    next_ptr = (last >= M - 1) ? '0 : N'(last + 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      grant_valid  <= '0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      rr_ptr       <= '0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      grant_valid  <= '0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      rr_ptr       <= '0;
    end else if (advance) begin
      out_valid    <= any_sel;
      grant_valid  <= sel_valid;
      grant_idx    <= sel_idx;
      grant_onehot <= sel_onehot;
      if (mode[1] && any_sel) rr_ptr <= next_ptr;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] grant_pop;

  always_comb begin
    grant_pop = '0;
    for (int j = 0; j < K; j++) grant_pop = grant_pop + {31'b0, grant_valid[j]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_valid && out_ready)  grant_cnt <= grant_cnt + grant_pop;
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multi_grant_arbiter.sv
// tb/tb_multi_grant_arbiter.sv - self-checking bench for multi_grant_arbiter (M=8 and M=6, K=2).
module tb_multi_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] req8;
  logic [1:0] mode8;
  logic       flush8, ready8;
  logic       ov8;
  logic [1:0] gv8;
  logic [5:0] idx8;
  logic [7:0] oh8;
  logic [2:0] ptr8;

  logic [5:0] req6;
  logic [1:0] mode6;
  logic       flush6, ready6;
  logic       ov6;
  logic [1:0] gv6;
  logic [5:0] idx6;
  logic [5:0] oh6;
  logic [2:0] ptr6;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] gc8, sc8, gc6, sc6;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        ov;
    logic [1:0]  gv;
    logic [2:0]  i1;
    logic [2:0]  i0;
    logic [7:0]  oh;
    logic [2:0]  ptr;
    logic [31:0] gc;
    logic [31:0] sc;
  } ms_t;

  ms_t m8, m6;

  always #5 clk = ~clk;

  multi_grant_arbiter #(.M(8), .K(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .mode(mode8), .flush(flush8),
    .out_ready(ready8), .out_valid(ov8), .grant_valid(gv8), .grant_idx(idx8),
    .grant_onehot(oh8),
`ifdef ARB_PERF_CNT_EN
    .grant_cnt(gc8), .stall_cnt(sc8),
`endif
    .rr_ptr(ptr8)
  );

  multi_grant_arbiter #(.M(6), .K(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .req(req6), .mode(mode6), .flush(flush6),
    .out_ready(ready6), .out_valid(ov6), .grant_valid(gv6), .grant_idx(idx6),
    .grant_onehot(oh6),
`ifdef ARB_PERF_CNT_EN
    .grant_cnt(gc6), .stall_cnt(sc6),
`endif
    .rr_ptr(ptr6)
  );

  // Reference: list positions in priority order, take the first two requested ones.
  function automatic ms_t mstep(input int m, input logic [7:0] r, input logic [1:0] md,
                                input logic rdy, input logic fl, input ms_t s);
    ms_t n;
    int order[$];
    int picked[$];
    logic [7:0] t;
    n = s;
`ifdef ARB_PERF_CNT_EN
    if (s.ov && rdy)  n.gc = s.gc + 32'(s.gv[0]) + 32'(s.gv[1]);
    if (s.ov && !rdy) n.sc = s.sc + 32'd1;
`endif
    if (fl) begin
      n = '0;
    end else if (!(s.ov && !rdy)) begin
      for (int o = 0; o < m; o++) begin
        if (md == 2'b00)      order.push_back(m - 1 - o);
        else if (md == 2'b01) order.push_back(o);
        else                  order.push_back((int'(s.ptr) + o) % m);
      end
      foreach (order[q]) begin
        t = r >> order[q];
        if (t[0] && picked.size() < 2) picked.push_back(order[q]);
      end
      n.ov = (picked.size() > 0);
      n.gv = '0;
      n.i0 = '0;
      n.i1 = '0;
      n.oh = '0;
      if (picked.size() > 0) begin
        n.gv[0] = 1'b1;
        n.i0    = 3'(picked[0]);
        n.oh    = n.oh | (8'd1 << picked[0]);
      end
      if (picked.size() > 1) begin
        n.gv[1] = 1'b1;
        n.i1    = 3'(picked[1]);
        n.oh    = n.oh | (8'd1 << picked[1]);
      end
      if (md[1] && picked.size() > 0) n.ptr = 3'((picked[picked.size()-1] + 1) % m);
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req8 = '0; mode8 = 2'b00; flush8 = 1'b0; ready8 = 1'b1;
    req6 = '0; mode6 = 2'b10; flush6 = 1'b0; ready6 = 1'b1;
    #2;
    checks++;
    if ({ov8, gv8, idx8, oh8, ptr8} !== 20'd0) begin
      failures++;
      $display("FAIL reset_init8 got=%h want=0", {ov8, gv8, idx8, oh8, ptr8});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mode8 = 2'b10; req8 = 8'hFF;
    tick();
    tick();
    checks++;
    if ({ov8, gv8, idx8, oh8, ptr8} !== {1'b1, 2'b11, 3'd3, 3'd2, 8'h0C, 3'd4}) begin
      failures++;
      $display("FAIL pre_reset_rr got=%h want=%h", {ov8, gv8, idx8, oh8, ptr8},
               {1'b1, 2'b11, 3'd3, 3'd2, 8'h0C, 3'd4});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ov8, gv8, idx8, oh8, ptr8} !== 20'd0) begin
      failures++;
      $display("FAIL async_reset8 got=%h want=0", {ov8, gv8, idx8, oh8, ptr8});
    end
    checks++;
    if ({ov6, gv6, idx6, oh6, ptr6} !== 18'd0) begin
      failures++;
      $display("FAIL async_reset6 got=%h want=0", {ov6, gv6, idx6, oh6, ptr6});
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_top_down();
    mode8 = 2'b00; req8 = 8'b1010_0110; ready8 = 1'b1;
    tick();
    checks++;
    if ({ov8, gv8, idx8, oh8, ptr8} !== {1'b1, 2'b11, 3'd5, 3'd7, 8'b1010_0000, 3'd0}) begin
      failures++;
      $display("FAIL top_down got=%h want=%h", {ov8, gv8, idx8, oh8, ptr8},
               {1'b1, 2'b11, 3'd5, 3'd7, 8'b1010_0000, 3'd0});
    end
  endtask

  task automatic test_bottom_up();
    mode8 = 2'b01; req8 = 8'b1010_0110;
    tick();
    checks++;
    if ({ov8, gv8, idx8, oh8, ptr8} !== {1'b1, 2'b11, 3'd2, 3'd1, 8'b0000_0110, 3'd0}) begin
      failures++;
      $display("FAIL bottom_up got=%h want=%h", {ov8, gv8, idx8, oh8, ptr8},
               {1'b1, 2'b11, 3'd2, 3'd1, 8'b0000_0110, 3'd0});
    end
    req8 = 8'b0000_1000;
    tick();
    checks++;
    if ({ov8, gv8, idx8, oh8, ptr8} !== {1'b1, 2'b01, 3'd0, 3'd3, 8'b0000_1000, 3'd0}) begin
      failures++;
      $display("FAIL single_req got=%h want=%h", {ov8, gv8, idx8, oh8, ptr8},
               {1'b1, 2'b01, 3'd0, 3'd3, 8'b0000_1000, 3'd0});
    end
  endtask

  task automatic test_rr_sweep();
    logic [19:0] want;
    mode8 = 2'b10; req8 = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      tick();
      want = {1'b1, 2'b11, 3'(2*c+1), 3'(2*c), 8'(8'd3 << (2*c)), 3'((2*c+2) % 8)};
      checks++;
      if ({ov8, gv8, idx8, oh8, ptr8} !== want) begin
        failures++;
        $display("FAIL rr_sweep%0d got=%h want=%h", c, {ov8, gv8, idx8, oh8, ptr8}, want);
      end
    end
  endtask

  task automatic test_stall_flush();
    ready8 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req8  = 8'($urandom);
      mode8 = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if ({ov8, gv8, idx8, oh8, ptr8} !== {1'b1, 2'b11, 3'd7, 3'd6, 8'hC0, 3'd0}) begin
        failures++;
        $display("FAIL stall%0d got=%h want=%h", c, {ov8, gv8, idx8, oh8, ptr8},
                 {1'b1, 2'b11, 3'd7, 3'd6, 8'hC0, 3'd0});
      end
    end
    flush8 = 1'b1;
    tick();
    flush8 = 1'b0;
    checks++;
    if ({ov8, gv8, idx8, oh8, ptr8} !== 20'd0) begin
      failures++;
      $display("FAIL flush got=%h want=0", {ov8, gv8, idx8, oh8, ptr8});
    end
    mode8 = 2'b11; req8 = 8'b1000_0001; ready8 = 1'b1;
    tick();
    checks++;
    if ({ov8, gv8, idx8, oh8, ptr8} !== {1'b1, 2'b11, 3'd7, 3'd0, 8'h81, 3'd0}) begin
      failures++;
      $display("FAIL mode11_wrap got=%h want=%h", {ov8, gv8, idx8, oh8, ptr8},
               {1'b1, 2'b11, 3'd7, 3'd0, 8'h81, 3'd0});
    end
  endtask

  task automatic test_empty();
    mode8 = 2'b10; req8 = 8'b0000_0100;
    tick();
    checks++;
    if ({ov8, gv8, idx8, oh8, ptr8} !== {1'b1, 2'b01, 3'd0, 3'd2, 8'h04, 3'd3}) begin
      failures++;
      $display("FAIL rr_single got=%h want=%h", {ov8, gv8, idx8, oh8, ptr8},
               {1'b1, 2'b01, 3'd0, 3'd2, 8'h04, 3'd3});
    end
    req8 = 8'h00;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({ov8, gv8, idx8, oh8, ptr8} !== {1'b0, 2'b00, 3'd0, 3'd0, 8'h00, 3'd3}) begin
        failures++;
        $display("FAIL empty%0d got=%h want=%h", c, {ov8, gv8, idx8, oh8, ptr8},
                 {1'b0, 2'b00, 3'd0, 3'd0, 8'h00, 3'd3});
      end
    end
`ifdef ARB_PERF_CNT_EN
    checks++;
    if (gc8 !== 32'd3 || sc8 !== 32'd0) begin
      failures++;
      $display("FAIL empty_counters got=%0d/%0d want=3/0", gc8, sc8);
    end
`endif
  endtask

  task automatic test_wrap6();
    mode6 = 2'b10; ready6 = 1'b1; req6 = 6'b11_1111;
    tick();
    tick();
    checks++;
    if ({ov6, gv6, idx6, oh6, ptr6} !== {1'b1, 2'b11, 3'd3, 3'd2, 6'b00_1100, 3'd4}) begin
      failures++;
      $display("FAIL m6_fill got=%h want=%h", {ov6, gv6, idx6, oh6, ptr6},
               {1'b1, 2'b11, 3'd3, 3'd2, 6'b00_1100, 3'd4});
    end
    req6 = 6'b00_0011;
    tick();
    checks++;
    if ({ov6, gv6, idx6, oh6, ptr6} !== {1'b1, 2'b11, 3'd1, 3'd0, 6'b00_0011, 3'd2}) begin
      failures++;
      $display("FAIL m6_wrap_a got=%h want=%h", {ov6, gv6, idx6, oh6, ptr6},
               {1'b1, 2'b11, 3'd1, 3'd0, 6'b00_0011, 3'd2});
    end
    req6 = 6'b01_0000;
    tick();
    checks++;
    if ({ov6, gv6, idx6, oh6, ptr6} !== {1'b1, 2'b01, 3'd0, 3'd4, 6'b01_0000, 3'd5}) begin
      failures++;
      $display("FAIL m6_to5 got=%h want=%h", {ov6, gv6, idx6, oh6, ptr6},
               {1'b1, 2'b01, 3'd0, 3'd4, 6'b01_0000, 3'd5});
    end
    req6 = 6'b10_0001;
    tick();
    checks++;
    if ({ov6, gv6, idx6, oh6, ptr6} !== {1'b1, 2'b11, 3'd0, 3'd5, 6'b10_0001, 3'd1}) begin
      failures++;
      $display("FAIL m6_wrap_b got=%h want=%h", {ov6, gv6, idx6, oh6, ptr6},
               {1'b1, 2'b11, 3'd0, 3'd5, 6'b10_0001, 3'd1});
    end
  endtask

  task automatic test_random();
    flush8 = 1'b1; flush6 = 1'b1;
    tick();
    flush8 = 1'b0; flush6 = 1'b0;
    m8 = '0;
    m6 = '0;
    for (int c = 0; c < 400; c++) begin
      req8   = 8'($urandom);
      mode8  = 2'($urandom_range(0, 3));
      ready8 = ($urandom_range(0, 3) != 0);
      flush8 = ($urandom_range(0, 31) == 0);
      req6   = 6'($urandom);
      mode6  = 2'($urandom_range(0, 3));
      ready6 = ($urandom_range(0, 3) != 0);
      flush6 = ($urandom_range(0, 31) == 0);
      m8 = mstep(8, req8, mode8, ready8, flush8, m8);
      m6 = mstep(6, {2'b00, req6}, mode6, ready6, flush6, m6);
      tick();
      checks++;
      if ({ov8, gv8, idx8, oh8, ptr8} !== {m8.ov, m8.gv, m8.i1, m8.i0, m8.oh, m8.ptr}) begin
        failures++;
        $display("FAIL rand8 cyc=%0d got=%h want=%h", c, {ov8, gv8, idx8, oh8, ptr8},
                 {m8.ov, m8.gv, m8.i1, m8.i0, m8.oh, m8.ptr});
      end
      checks++;
      if ({ov6, gv6, idx6, oh6, ptr6} !== {m6.ov, m6.gv, m6.i1, m6.i0, m6.oh[5:0], m6.ptr}) begin
        failures++;
        $display("FAIL rand6 cyc=%0d got=%h want=%h", c, {ov6, gv6, idx6, oh6, ptr6},
                 {m6.ov, m6.gv, m6.i1, m6.i0, m6.oh[5:0], m6.ptr});
      end
`ifdef ARB_PERF_CNT_EN
      checks++;
      if ({gc8, sc8, gc6, sc6} !== {m8.gc, m8.sc, m6.gc, m6.sc}) begin
        failures++;
        $display("FAIL rand_cnt cyc=%0d got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", c,
                 gc8, sc8, gc6, sc6, m8.gc, m8.sc, m6.gc, m6.sc);
      end
`endif
    end
    flush8 = 1'b0; flush6 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_top_down();
    test_bottom_up();
    test_rr_sweep();
    test_stall_flush();
    test_empty();
    test_wrap6();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_grant_arbiter.md
Name: multi_grant_arbiter

Overview:
- Parametrised, registered successor to the combinational single-pick priority encoder.
- Each accepted cycle it selects up to K requesters out of M. Selection is fixed top-down, fixed bottom-up, or round-robin with a rotating start pointer.
- Grants are presented on a registered valid/ready output stage.
- Sits between the issue-queue ready vector and the functional-unit dispatch ports in mips_core.

Parameters:
- M, 16, number of request lines (M >= 2).
- K, 2, maximum grants per cycle (1 <= K <= M).
- N, $clog2(M), index width (derived; do not override).

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- req  input  M  request vector; bit i = requester i
- mode  input  2  00 fixed top-down (M-1 highest), 01 fixed bottom-up (0 highest), 10 round-robin, 11 treated as 10
- flush  input  1  synchronous clear of the output stage and the pointer
- out_ready  input  1  consumer accepts the current grant set
- out_valid  output  1  OR of grant_valid
- grant_valid  output  K  slot j holds a valid grant
- grant_idx  output  K*N  slot j index at bits [j*N +: N]; 0 when the slot is invalid
- grant_onehot  output  M  OR of all granted one-hots
- rr_ptr  output  N  current round-robin start pointer (debug/verification)

Behaviour:
- Reset (rst_n low, asynchronous): out_valid, grant_valid, grant_idx, grant_onehot and rr_ptr all 0. Deassertion is applied synchronously; the first evaluation happens on the first clk edge with rst_n high.
- Accept condition: advance = !out_valid || out_ready.
- Latency: req/mode sampled on a clk edge with advance=1 appear on the outputs after that edge (1 cycle).
- Selection (combinational, from req):
  - Slot 0 takes the highest-priority set bit.
  - Slot j takes the highest-priority set bit not taken by slots 0..j-1.
  - Slots with no remaining request: grant_valid[j]=0, index 0.
  - Top-down: scan M-1 down to 0.
  - Bottom-up: scan 0 up to M-1.
  - Round-robin: scan rr_ptr, rr_ptr+1, ... wrapping M-1 -> 0; each index is visited at most once per cycle.
- Pointer update (only on an advance edge, round-robin mode, at least one grant): rr_ptr <= (index of last valid slot + 1) mod M.
  - Wrap for non-power-of-2 M is explicit: index M-1 -> 0. The pointer never holds a value >= M.
  - No grant, fixed modes, or stalled: rr_ptr holds.
- Stall (out_valid=1, out_ready=0): all output registers and rr_ptr hold; req changes are ignored.
- Empty request (req=0 on an advance edge): output stage loads all-zero (out_valid=0); rr_ptr holds.
- Flush: on the next edge, output registers go to 0 and rr_ptr to 0.
  - Flush overrides stall and advance.
  - The req sampled in the flush cycle is discarded.
- Mode change takes effect at the next advance edge. rr_ptr is preserved across mode changes.
- Reset mid-stall returns everything to the reset values immediately.
- Grants are distinct: no index appears in two valid slots in the same cycle.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds two 32-bit outputs, each cleared by rst_n and flush and wrapping at 2^32.
  - grant_cnt accumulates popcount(grant_valid) on each accepted transfer (out_valid && out_ready).
  - stall_cnt increments on each cycle with out_valid=1 and out_ready=0.
- Not defined: both ports and their counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset and top-down (M=8, K=2): pulse rst_n low mid-operation -> all outputs 0 asynchronously, rr_ptr=0. Then mode=00, req=8'b1010_0110, out_ready=1 -> next cycle grant_valid=2'b11, idx0=7, idx1=5, grant_onehot=8'b1010_0000.
- Bottom-up and single request: mode=01, req=8'b1010_0110 -> idx0=1, idx1=2. Then req=8'b0000_1000 -> grant_valid=2'b01, idx0=3, idx1=0.
- Round-robin sweep: mode=10, req=8'hFF, out_ready=1 for 4 cycles -> grant pairs (0,1), (2,3), (4,5), (6,7); rr_ptr 2, 4, 6, 0.
- Wrap and non-power-of-2: M=6, rr_ptr=4, req=6'b00_0011 -> idx0=0, idx1=1, rr_ptr=2. Then rr_ptr=5, req=6'b10_0001 -> idx0=5, idx1=0, rr_ptr=1.
- Stall then flush: out_ready=0 for 3 cycles while req changes -> outputs and rr_ptr frozen. Then flush=1 with out_ready=0 -> next cycle out_valid=0, rr_ptr=0.
- Empty request: req=0 with out_ready=1 -> out_valid=0, grant_onehot=0, rr_ptr unchanged. With ARB_PERF_CNT_EN defined, grant_cnt is unchanged and stall_cnt does not increment.
